// File: rtl/i2c_pkg.sv
// Shared types and status-word layout for the I2C master and sniffer.
package i2c_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    BIT,
    ACK,
    HOLD,
    STOP
  } i2c_state_e;

  typedef logic [1:0] qtr_idx_t;

  localparam int STATUS_W = 9;
  localparam int NACK_BIT = 0;
  localparam int DATA_MSB = 8;
  localparam int DATA_LSB = 1;

endpackage

// File: rtl/i2c_qtr_tick.sv
// SCL quarter-period divider: down-counter that pulses qtick at terminal count.
// hold keeps the counter parked at its reload value so the next quarter is full length.
module i2c_qtr_tick #(
  parameter int QTR_CYCLES = 250
) (
  input  logic clk,
  input  logic rst,
  input  logic hold,
  output logic qtick
);

  localparam int CW = (QTR_CYCLES > 2) ? $clog2(QTR_CYCLES) : 1;
  localparam logic [CW-1:0] RELOAD = CW'(QTR_CYCLES - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= RELOAD;
    end else if (hold || cnt == '0) begin
      cnt <= RELOAD;
    end else begin
      cnt <= cnt - 1'b1;
    end
  end

  assign qtick = !hold && (cnt == '0);

endmodule

// File: rtl/i2c_bitbang_master.sv
// Open-drain I2C write master: streams bytes out with START/ACK/STOP and reports {byte, nack}.
// Define I2C_STRETCH_EN to honour slave clock stretching via scl_in.
//
// state | meaning
// IDLE  | bus released, waiting for first byte
// START | q0 SDA low, q1 SCL low
// BIT   | 4 quarters per data bit, MSB first
// ACK   | SDA released, slave ACK sampled at end of q2
// HOLD  | SCL held low between bytes, waiting for next byte
// STOP  | q0 SCL/SDA low, q1 SCL released, q2 SDA released
module i2c_bitbang_master
  import i2c_pkg::*;
#(
  parameter int QTR_CYCLES  = 250,
  parameter int SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [7:0]          tx_data,
  input  logic                tx_last,
  input  logic                tx_valid,
  output logic                tx_ready,
  output logic                scl_oe,
  output logic                sda_oe,
  input  logic                scl_in,
  input  logic                sda_in,
  output logic [STATUS_W-1:0] status_word,
  output logic                status_valid,
  output logic                busy
);

  i2c_state_e state;
  qtr_idx_t   qtr;
  logic [2:0] bit_idx;
  logic [7:0] data_q;
  logic       last_q;
  logic       nack_q;
  logic       ready_en;
  logic       qtick;
  logic       stretch_wait;
  logic       accept;
  logic [SYNC_STAGES-1:0] sda_sync_q;
  logic       sda_sync;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sda_sync_q <= '1;
    end else begin
      sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda_in};
    end
  end
  assign sda_sync = sda_sync_q[SYNC_STAGES-1];

`ifdef I2C_STRETCH_EN
  logic [SYNC_STAGES-1:0] scl_sync_q;
  logic                   scl_released_qtr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scl_sync_q <= '1;
    end else begin
      scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl_in};
    end
  end

  // Quarters that begin with SCL just released: time them from the observed rising edge.
  assign scl_released_qtr = ((state == BIT || state == ACK) && qtr == 2'd2) ||
                            (state == STOP && qtr == 2'd1);
  assign stretch_wait = scl_released_qtr && !scl_sync_q[SYNC_STAGES-1];
`else
  logic scl_unused;
  assign scl_unused   = scl_in;
  assign stretch_wait = 1'b0;
`endif

  i2c_qtr_tick #(
    .QTR_CYCLES(QTR_CYCLES)
  ) u_qtr_tick (
    .clk  (clk),
    .rst  (rst),
    .hold ((state == IDLE) || (state == HOLD) || stretch_wait),
    .qtick(qtick)
  );

  assign tx_ready = ready_en && ((state == IDLE) || (state == HOLD));
  assign accept   = tx_valid && tx_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      qtr          <= '0;
      bit_idx      <= '0;
      data_q       <= '0;
      last_q       <= 1'b0;
      nack_q       <= 1'b0;
      scl_oe       <= 1'b0;
      sda_oe       <= 1'b0;
      busy         <= 1'b0;
      status_word  <= '0;
      status_valid <= 1'b0;
      ready_en     <= 1'b0;
    end else begin
      status_valid <= 1'b0;
      ready_en     <= 1'b1;
      case (state)
        IDLE: begin
          if (accept) begin
            data_q <= tx_data;
            last_q <= tx_last;
            busy   <= 1'b1;
            sda_oe <= 1'b1;
            qtr    <= '0;
            state  <= START;
          end
        end
        START: begin
          if (qtick) begin
            if (qtr == 2'd0) begin
              scl_oe <= 1'b1;
              qtr    <= 2'd1;
            end else begin
              qtr     <= '0;
              bit_idx <= 3'd7;
              sda_oe  <= ~data_q[7];
              state   <= BIT;
            end
          end
        end
        BIT: begin
          if (qtick) begin
            qtr <= qtr + 2'd1;
            if (qtr == 2'd1) begin
              scl_oe <= 1'b0;
            end else if (qtr == 2'd3) begin
              scl_oe <= 1'b1;
              if (bit_idx == 3'd0) begin
                sda_oe <= 1'b0;
                state  <= ACK;
              end else begin
                bit_idx <= bit_idx - 3'd1;
                sda_oe  <= ~data_q[bit_idx - 3'd1];
              end
            end
          end
        end
        ACK: begin
          if (qtick) begin
            qtr <= qtr + 2'd1;
            if (qtr == 2'd1) begin
              scl_oe <= 1'b0;
            end else if (qtr == 2'd2) begin
              nack_q <= sda_sync;
            end else if (qtr == 2'd3) begin
              scl_oe                       <= 1'b1;
              status_word[DATA_MSB:DATA_LSB] <= data_q;
              status_word[NACK_BIT]        <= nack_q;
              status_valid                 <= 1'b1;
              // A NACK anywhere ends the transaction; later bytes stay with the host.
              if (nack_q || last_q) begin
                sda_oe <= 1'b1;
                state  <= STOP;
              end else begin
                state <= HOLD;
              end
            end
          end
        end
        HOLD: begin
          if (accept) begin
            data_q  <= tx_data;
            last_q  <= tx_last;
            qtr     <= '0;
            bit_idx <= 3'd7;
            sda_oe  <= ~tx_data[7];
            state   <= BIT;
          end
        end
        STOP: begin
          if (qtick) begin
            qtr <= qtr + 2'd1;
            if (qtr == 2'd0) begin
              scl_oe <= 1'b0;
            end else if (qtr == 2'd1) begin
              sda_oe <= 1'b0;
            end else begin
              qtr      <= '0;
              busy     <= 1'b0;
              ready_en <= 1'b0;
              state    <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/i2c_bitbang_master.md
Name: i2c_bitbang_master

Overview:
- Open-drain I2C write initiator; the transmit-side counterpart of the I2C sniffer.
- Takes bytes over a valid/ready stream and emits START, address/data bytes MSB-first, samples ACK, and emits STOP.
- Used to inject PMIC register writes (e.g. DAC level) onto the priv/main buses.
- Reports each byte's ACK result in the same 9-bit {byte, nack} word format the sniffer produces, so the two can be cross-checked.

Parameters:
- QTR_CYCLES, 250: clk cycles per SCL quarter-period; 4 quarters = 1 bit time (100 kHz at 100 MHz). Must be >= 2.
- SYNC_STAGES, 2: flop stages on scl_in/sda_in.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- tx_data  in  8  byte to send (first byte of a transaction = {addr, r/w})
- tx_last  in  1  byte is final of transaction; STOP follows it
- tx_valid  in  1  tx_data/tx_last valid
- tx_ready  out  1  byte accepted when tx_valid && tx_ready
- scl_oe  out  1  1 = pull SCL low, 0 = release
- sda_oe  out  1  1 = pull SDA low, 0 = release
- scl_in  in  1  SCL pad level
- sda_in  in  1  SDA pad level
- status_word  out  9  [8:1] byte sent, [0] nack (1 = NACK seen)
- status_valid  out  1  one-cycle pulse per completed byte
- busy  out  1  high from START through end of STOP

Behaviour:
- Reset values: scl_oe = 0, sda_oe = 0 (bus released), tx_ready = 0 until first cycle after reset, status_word = 0, status_valid = 0, busy = 0, state = IDLE. Reset mid-transaction releases both lines immediately; no STOP is generated.
- Quarter tick: a counter reloads at QTR_CYCLES-1 and pulses qtick at 0. All state changes happen only on qtick. The counter is held at reload while in IDLE or HOLD.
- tx_ready = (state == IDLE) || (state == HOLD). It is combinational from state.
- IDLE: both lines released. On accept, latch byte/last, busy = 1, go to START.
- START (2 quarters, SCL released): q0 sda_oe = 1; q1 scl_oe = 1. Then go to BIT with bit index 7.
- BIT (4 quarters per bit):
  - q0: SCL low, sda_oe = ~bit[i].
  - q1: SCL low.
  - q2: release SCL.
  - q3: SCL high.
  - After q3, decrement i. At i = 0, go to ACK.
- ACK (4 quarters, sda_oe = 0): sample synced SDA at the end of q2 (nack = sda). After q3, set scl_oe = 1, status_word = {byte, nack}, status_valid = 1 for one cycle.
- After ACK:
  - nack || last → STOP.
  - Otherwise → HOLD.
- HOLD: SCL held low, SDA released, waits indefinitely. On accept, go to BIT with the new byte (no repeated START).
- STOP (3 quarters):
  - q0: SCL low, sda_oe = 1.
  - q1: release SCL.
  - q2: release SDA.
  - Then IDLE, busy = 0. tx_ready first asserts one cycle after busy falls.
- NACK on a non-last byte aborts with STOP. Remaining bytes of that transaction stay on the input; the host must flush or resend them.
- tx_valid arriving mid-byte is ignored until the next ready window; it is never dropped once accepted.
- Latency from accept in IDLE to first SDA fall: ≤ QTR_CYCLES+1 cycles. Full single-byte transaction = (2 + 32 + 4 + 3) × QTR_CYCLES cycles.

Optional Feature:
- Macro: I2C_STRETCH_EN.
- Defined: on every quarter where SCL was just released, the quarter counter is held until synced scl_in reads 1. Slave clock stretching therefore lengthens the low phase, and the high phase is timed from the observed rising edge.
- Undefined: scl_in is unused and timing is purely open-loop; scl_in must still be connected.

Decomposition:
- Package i2c_pkg holds:
  - state enum {IDLE, START, BIT, ACK, HOLD, STOP}
  - quarter index type
  - STATUS_W = 9, NACK_BIT = 0, DATA_MSB = 8, DATA_LSB = 1, shared with the sniffer.
- Sub-module i2c_qtr_tick: quarter-period divider with hold input (QTR_CYCLES parameter, outputs qtick).

Test Plan:
- QTR_CYCLES = 4. Send 0x5A (last), slave ACKs (sda_in = 0 during ACK) → SDA bits 0,1,0,1,1,0,1,0 stable while SCL high; status_word = 0x0B4, one status_valid pulse; STOP seen; busy low after 164 cycles.
- Send 3-byte stream 0x90, 0x12, 0x34 (last on 0x34), all ACKed → one START, three status words 0x120/0x024/0x068, one STOP, SCL low during HOLD gaps when tx_valid is delayed 20 cycles.
- Send 0x90 then 0x12, slave NACKs 0x90 → status_word = 0x121, STOP immediately, 0x12 not accepted, tx_ready high in IDLE.
- Assert rst during bit 3 of a byte → scl_oe = sda_oe = 0 in the same cycle (async), busy = 0, status_valid never pulses.
- With I2C_STRETCH_EN, hold scl_in = 0 for 30 cycles after the ACK-phase SCL release → the ACK high phase starts only after scl_in rises; sample still correct (status nack = 0).
- Loopback: pipe scl/sda through wired-AND into the sniffer, send 0xA5 (last) → sniffer emits 0x14A with ready, matching status_word.
